// File: rtl/copy_n.sv
// rtl/copy_n.sv - one-to-N token replicator with an independent FIFO per output channel
//
// Each accepted input token is written into the FIFO of every channel enabled
// in out_en. Each channel then drains on its own valid/ready handshake.
// Acceptance requires room in every enabled channel, so a slow consumer can
// only stall new input. It never stalls another channel's drain.
//
// Optional feature macro: COPY_N_STATS_EN adds the accept_count and drop_count
// outputs.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   in_data      input token (WIDTH bits)
//   in_valid     producer offers in_data
//   in_ready     token accepted this cycle when in_valid is also high
//   out_en       per-channel enable mask (N bits)
//   out_data     channel i token at [i*WIDTH +: WIDTH]
//   out_valid    channel i holds a token
//   out_ready    consumer i takes the head token
//   busy         registered: some channel FIFO is non-empty
//   accept_count (COPY_N_STATS_EN) accepted tokens, wraps at 16 bits
//   drop_count   (COPY_N_STATS_EN) tokens accepted with out_en all zero
module copy_n #(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       out_en,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               busy
`ifdef COPY_N_STATS_EN
  ,
  output logic [15:0]        accept_count,
  output logic [15:0]        drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [N][DEPTH];
  logic [AW-1:0]    wptr [N];
  logic [AW-1:0]    rptr [N];
  logic [CW-1:0]    count [N];
  logic [CW-1:0]    count_next [N];

  logic [N-1:0] full;
  logic [N-1:0] push;
  logic [N-1:0] pop;
  logic [N-1:0] nonempty_next;
  logic         accept;

  always_comb begin
    full          = '0;
    push          = '0;
    pop           = '0;
    nonempty_next = '0;
    out_valid     = '0;
    out_data      = '0;
    for (int i = 0; i < N; i++) begin
      full[i]      = (count[i] == CW'(DEPTH));
      out_valid[i] = (count[i] != '0);
      // Zero the data of an empty channel so that reset leaves out_data at 0
      // without clearing the storage array.
      if (out_valid[i])
        out_data[i*WIDTH +: WIDTH] = mem[i][rptr[i]];
    end
    // Readiness uses only registered occupancy and the enable mask. It never
    // uses out_ready, so a full FIFO blocks input even when it pops this cycle.
    in_ready = !rst && ((full & out_en) == '0);
    accept   = in_valid && in_ready;
    for (int i = 0; i < N; i++) begin
      push[i]          = accept && out_en[i];
      pop[i]           = out_valid[i] && out_ready[i];
      count_next[i]    = count[i] + CW'(push[i]) - CW'(pop[i]);
      nonempty_next[i] = (count_next[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
      busy <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) begin
          mem[i][wptr[i]] <= in_data;
          wptr[i]         <= wptr[i] + AW'(1);
        end
        if (pop[i])
          rptr[i] <= rptr[i] + AW'(1);
        count[i] <= count_next[i];
      end
      // Registered from next-state occupancy, so busy lines up with out_valid.
      busy <= |nonempty_next;
    end
  end

`ifdef COPY_N_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_count <= '0;
      drop_count   <= '0;
    end else if (accept) begin
      accept_count <= accept_count + 16'd1;
      if (out_en == '0)
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_copy_n.sv
// tb/tb_copy_n.sv - self-checking bench for copy_n against a per-channel queue model
module tb_copy_n;

  localparam int WIDTH = 8;
  localparam int N     = 3;
  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       out_en;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic               busy;
`ifdef COPY_N_STATS_EN
  logic [15:0]        accept_count;
  logic [15:0]        drop_count;
`endif

  always #5 clk = ~clk;

  copy_n #(.WIDTH(WIDTH), .N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_en    (out_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef COPY_N_STATS_EN
    ,
    .accept_count (accept_count),
    .drop_count   (drop_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue of expected tokens per channel.
  logic [WIDTH-1:0] q [N][$];
  logic [15:0]      acc_m = 16'd0;
  logic [15:0]      drop_m = 16'd0;

  logic               last_ready;
  logic [N-1:0]       last_valid;
  logic [N*WIDTH-1:0] last_data;
  logic               last_busy;
  logic               last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d,
                      input logic [N-1:0] en, input logic [N-1:0] rd);
    logic exp_ready;
    logic any;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_en    = en;
    out_ready = rd;
    #1;
    exp_ready = !r;
    for (int i = 0; i < N; i++)
      if (en[i] && q[i].size() >= DEPTH) exp_ready = 1'b0;
    check("in_ready", in_ready, exp_ready);
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("out_valid", out_valid[i], q[i].size() > 0);
      if (q[i].size() > 0) begin
        check("out_data", out_data[i*WIDTH +: WIDTH], q[i][0]);
        any = 1'b1;
      end
    end
    check("busy", busy, any);
`ifdef COPY_N_STATS_EN
    check("accept_count", accept_count, acc_m);
    check("drop_count", drop_count, drop_m);
`endif
    last_ready = in_ready;
    last_valid = out_valid;
    last_data  = out_data;
    last_busy  = busy;
    last_acc   = 1'b0;
    if (r) begin
      for (int i = 0; i < N; i++) q[i].delete();
      acc_m  = 16'd0;
      drop_m = 16'd0;
    end else begin
      for (int i = 0; i < N; i++)
        if (q[i].size() > 0 && rd[i]) void'(q[i].pop_front());
      if (v && exp_ready) begin
        last_acc = 1'b1;
        acc_m++;
        if (en == '0) drop_m++;
        for (int i = 0; i < N; i++)
          if (en[i]) q[i].push_back(d);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  int accepted;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_en = '0; out_ready = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);

    // Scenario A: broadcast, all consumers ready.
    step(0, 1, 8'h5A, 3'b111, 3'b111);
    step(0, 0, 8'h00, 3'b111, 3'b111);
    check("A_valid", last_valid, 3'b111);
    check("A_data", last_data, {3{8'h5A}});
    step(0, 0, 8'h00, 3'b111, 3'b111);
    check("A_busy", last_busy, 0);

    // Scenario B: channel 1 stalls, so the third token waits for its first pop.
    step(0, 1, 8'h01, 3'b111, 3'b101);
    check("B_rdy1", last_ready, 1);
    step(0, 1, 8'h02, 3'b111, 3'b101);
    check("B_rdy2", last_ready, 1);
    step(0, 1, 8'h03, 3'b111, 3'b101);
    check("B_rdy3", last_ready, 0);
    step(0, 1, 8'h03, 3'b111, 3'b111);
    check("B_rdy_at_pop", last_ready, 0);
    step(0, 1, 8'h03, 3'b111, 3'b111);
    check("B_rdy_after_pop", last_ready, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 8'h00, 3'b111, 3'b111);

    // Scenario C: partial enable, from a fresh reset so the counters start at zero.
    step(1, 0, 8'h00, 3'b000, 3'b111);
    step(0, 1, 8'h33, 3'b101, 3'b000);
    step(0, 0, 8'h00, 3'b101, 3'b000);
    check("C_valid", last_valid, 3'b101);
    check("C_data0", last_data[7:0], 8'h33);
    check("C_data2", last_data[23:16], 8'h33);
`ifdef COPY_N_STATS_EN
    check("C_accept_count", accept_count, 16'd1);
    check("C_drop_count", drop_count, 16'd0);
`endif
    step(0, 0, 8'h00, 3'b101, 3'b111);

    // Scenario D: no channel enabled, so the token is accepted and dropped.
    step(0, 1, 8'h44, 3'b000, 3'b111);
    check("D_ready", last_ready, 1);
    step(0, 0, 8'h00, 3'b000, 3'b111);
    check("D_valid", last_valid, 0);
`ifdef COPY_N_STATS_EN
    check("D_drop_count", drop_count, 16'd1);
`endif

    // Scenario E: reset discards full FIFOs.
    step(0, 1, 8'h10, 3'b111, 3'b000);
    step(0, 1, 8'h11, 3'b111, 3'b000);
    step(0, 1, 8'h12, 3'b111, 3'b000);
    check("E_full_ready", last_ready, 0);
    step(1, 0, 8'h00, 3'b111, 3'b000);
    check("E_rst_ready", last_ready, 0);
    step(0, 0, 8'h00, 3'b111, 3'b111);
    check("E_valid", last_valid, 0);
    check("E_busy", last_busy, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 8'h00, 3'b111, 3'b111);
      check("E_no_stale", last_valid, 0);
    end

    // Scenario F: 1000 accepted random tokens with random enables and back-pressure.
    accepted = 0;
    out_en = 3'b111;
    for (int cyc = 0; cyc < 20000 && accepted < 1000; cyc++) begin
      logic [N-1:0] en;
      en = out_en;
      if ($urandom_range(0, 7) == 0) en = N'($urandom);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
           WIDTH'($urandom), en, N'($urandom));
      if (last_acc) accepted++;
    end
    check("F_accepted", accepted, 1000);
    for (int k = 0; k < 2 * DEPTH + 2; k++) step(0, 0, 8'h00, 3'b000, 3'b111);
    check("F_drained_busy", last_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
